// File: rtl/decode_stage_pkg.sv
// Shared RV32I/RV32M encodings and the decoded-instruction bundle.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Base codes 0-9 fit a 4-bit ALU; the M group extends into 10-17.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef struct packed {
    alu_op_e     alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decoder: raw instruction to decoded bundle.
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0] instr_i,
  output dec_bundle_t dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                   instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                   instr_i[30:21], 1'b0};

  // Field extraction and ALU/control selection per opcode class.
  always_comb begin
    dec_o = '0;
    unique case (opcode)
      OPC_OP: begin
        dec_o.rs1       = instr_i[19:15];
        dec_o.rs2       = instr_i[24:20];
        dec_o.rd        = instr_i[11:7];
        dec_o.reg_write = 1'b1;
        case (f7)
          FUNCT7_BASE: begin
            case (f3)
              FUNCT3_ADD:  dec_o.alu_op = ALU_ADD;
              FUNCT3_SLL:  dec_o.alu_op = ALU_SLL;
              FUNCT3_SLT:  dec_o.alu_op = ALU_SLT;
              FUNCT3_SLTU: dec_o.alu_op = ALU_SLTU;
              FUNCT3_XOR:  dec_o.alu_op = ALU_XOR;
              FUNCT3_SR:   dec_o.alu_op = ALU_SRL;
              FUNCT3_OR:   dec_o.alu_op = ALU_OR;
              default:     dec_o.alu_op = ALU_AND;
            endcase
          end
          FUNCT7_ALT: begin
            if (f3 == FUNCT3_ADD)     dec_o.alu_op  = ALU_SUB;
            else if (f3 == FUNCT3_SR) dec_o.alu_op  = ALU_SRA;
            else                      dec_o.illegal = 1'b1;
          end
          FUNCT7_MULDIV: begin
            if (ENABLE_M != 0) begin
              case (f3)
                3'b000:  dec_o.alu_op = ALU_MUL;
                3'b001:  dec_o.alu_op = ALU_MULH;
                3'b010:  dec_o.alu_op = ALU_MULHSU;
                3'b011:  dec_o.alu_op = ALU_MULHU;
                3'b100:  dec_o.alu_op = ALU_DIV;
                3'b101:  dec_o.alu_op = ALU_DIVU;
                3'b110:  dec_o.alu_op = ALU_REM;
                default: dec_o.alu_op = ALU_REMU;
              endcase
            end else begin
              dec_o.illegal = 1'b1;
            end
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_o.rs1         = instr_i[19:15];
        dec_o.rd          = instr_i[11:7];
        dec_o.imm         = imm_i;
        dec_o.alu_src_imm = 1'b1;
        dec_o.reg_write   = 1'b1;
        case (f3)
          FUNCT3_ADD:  dec_o.alu_op = ALU_ADD;
          FUNCT3_SLT:  dec_o.alu_op = ALU_SLT;
          FUNCT3_SLTU: dec_o.alu_op = ALU_SLTU;
          FUNCT3_XOR:  dec_o.alu_op = ALU_XOR;
          FUNCT3_OR:   dec_o.alu_op = ALU_OR;
          FUNCT3_AND:  dec_o.alu_op = ALU_AND;
          FUNCT3_SLL: begin
            if (f7 == FUNCT7_BASE) dec_o.alu_op  = ALU_SLL;
            else                   dec_o.illegal = 1'b1;
          end
          default: begin
            if (f7 == FUNCT7_BASE)     dec_o.alu_op  = ALU_SRL;
            else if (f7 == FUNCT7_ALT) dec_o.alu_op  = ALU_SRA;
            else                       dec_o.illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD: begin
        dec_o.rs1         = instr_i[19:15];
        dec_o.rd          = instr_i[11:7];
        dec_o.imm         = imm_i;
        dec_o.alu_src_imm = 1'b1;
        dec_o.mem_read    = 1'b1;
        dec_o.reg_write   = 1'b1;
        dec_o.illegal     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_o.rs1         = instr_i[19:15];
        dec_o.rs2         = instr_i[24:20];
        dec_o.imm         = imm_s;
        dec_o.alu_src_imm = 1'b1;
        dec_o.mem_write   = 1'b1;
        dec_o.illegal     = f3[2] || (f3 == 3'b011);
      end
      OPC_BRANCH: begin
        dec_o.rs1     = instr_i[19:15];
        dec_o.rs2     = instr_i[24:20];
        dec_o.imm     = imm_b;
        dec_o.alu_op  = ALU_SUB;
        dec_o.branch  = 1'b1;
        dec_o.illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_o.rd          = instr_i[11:7];
        dec_o.imm         = imm_u;
        dec_o.alu_src_imm = 1'b1;
        dec_o.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        dec_o.rd          = instr_i[11:7];
        dec_o.imm         = imm_j;
        dec_o.alu_src_imm = 1'b1;
        dec_o.reg_write   = 1'b1;
        dec_o.jump        = 1'b1;
      end
      OPC_JALR: begin
        dec_o.rs1         = instr_i[19:15];
        dec_o.rd          = instr_i[11:7];
        dec_o.imm         = imm_i;
        dec_o.alu_src_imm = 1'b1;
        dec_o.reg_write   = 1'b1;
        dec_o.jump        = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
    // Illegal bundles still flow to execute for trapping, but with no side effects.
    if (dec_o.illegal) begin
      dec_o.reg_write = 1'b0;
      dec_o.mem_read  = 1'b0;
      dec_o.mem_write = 1'b0;
      dec_o.branch    = 1'b0;
      dec_o.jump      = 1'b0;
    end
    if (dec_o.rd == 5'd0) dec_o.reg_write = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready pipeline register around decode_comb.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 0,
  localparam int ALU_OP_W = (ENABLE_M != 0) ? 5 : 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_imm,
  output logic                out_alu_src_imm,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_illegal
);

  dec_bundle_t     dec;
  dec_bundle_t     bundle_d, bundle_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            valid_d, valid_q;
  logic            accept;
  logic            unused_alu_bits;

  decode_comb #(.ENABLE_M(ENABLE_M)) u_decode_comb (
    .instr_i (in_instr),
    .dec_o   (dec)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Next-state: flush beats accept; a consumed bundle without refill goes invalid.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec;
      pc_d     = in_pc;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register; reset clears every output field.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
    end
  end

  assign unused_alu_bits = ^bundle_q.alu_op;

  assign out_valid       = valid_q;
  assign out_pc          = pc_q;
  assign out_alu_op      = bundle_q.alu_op[ALU_OP_W-1:0];
  assign out_rs1         = bundle_q.rs1;
  assign out_rs2         = bundle_q.rs2;
  assign out_rd          = bundle_q.rd;
  assign out_imm         = bundle_q.imm;
  assign out_alu_src_imm = bundle_q.alu_src_imm;
  assign out_reg_write   = bundle_q.reg_write;
  assign out_mem_read    = bundle_q.mem_read;
  assign out_mem_write   = bundle_q.mem_write;
  assign out_branch      = bundle_q.branch;
  assign out_jump        = bundle_q.jump;
  assign out_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance without and one with the M group.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready0, out_valid0, src0, rw0, mr0, mw0, br0, j0, ill0;
  logic [31:0] pc0, imm0;
  logic [3:0]  alu0;
  logic [4:0]  rs1_0, rs2_0, rd0;

  logic        in_ready1, out_valid1, src1, rw1, mr1, mw1, br1, j1, ill1;
  logic [31:0] pc1, imm1;
  logic [4:0]  alu1;
  logic [4:0]  rs1_1, rs2_1, rd1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .ENABLE_M(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
    .out_pc(pc0), .out_alu_op(alu0), .out_rs1(rs1_0), .out_rs2(rs2_0), .out_rd(rd0),
    .out_imm(imm0), .out_alu_src_imm(src0), .out_reg_write(rw0), .out_mem_read(mr0),
    .out_mem_write(mw0), .out_branch(br0), .out_jump(j0), .out_illegal(ill0)
  );

  decode_stage #(.XLEN(32), .ENABLE_M(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
    .out_pc(pc1), .out_alu_op(alu1), .out_rs1(rs1_1), .out_rs2(rs2_1), .out_rd(rd1),
    .out_imm(imm1), .out_alu_src_imm(src1), .out_reg_write(rw1), .out_mem_read(mr1),
    .out_mem_write(mw1), .out_branch(br1), .out_jump(j1), .out_illegal(ill1)
  );

  // Observed bundles: {alu(5), rs1, rs2, rd, imm, src, rw, mr, mw, br, j, ill}
  logic [58:0] obs0, obs1;
  assign obs0 = {1'b0, alu0, rs1_0, rs2_0, rd0, imm0, src0, rw0, mr0, mw0, br0, j0, ill0};
  assign obs1 = {alu1, rs1_1, rs2_1, rd1, imm1, src1, rw1, mr1, mw1, br1, j1, ill1};

  // Expected-bundle builder; ctl = {src, rw, mr, mw, br, j, ill}
  function automatic logic [58:0] exp_b(input logic [4:0] alu, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic [31:0] imm, input logic [6:0] ctl);
    return {alu, rs1, rs2, rd, imm, ctl};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (out_valid0 !== 1'b0 || obs0 !== '0 || pc0 !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%b bundle=%h pc=%h, want 0/0/0", out_valid0, obs0, pc0);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b valid=%b, want 1/0", in_ready0, out_valid0);
    end
  endtask

  task automatic test_decode_vector(input string name, input logic [31:0] instr,
                                    input logic [58:0] want);
    send(instr, 32'h0000_1000);
    tests++;
    if (out_valid0 !== 1'b1 || obs0 !== want || pc0 !== 32'h0000_1000) begin
      fails++;
      $display("FAIL %s: valid=%b bundle=%h pc=%h, want 1 %h 00001000", name, out_valid0,
               obs0, pc0, want);
    end
  endtask

  task automatic test_decode();
    test_decode_vector("sub", 32'h40B50533, exp_b(5'd1, 5'd10, 5'd11, 5'd10, 32'h0, 7'b0100000));
    test_decode_vector("addi_neg1", 32'hFFF00093,
                       exp_b(5'd0, 5'd0, 5'd0, 5'd1, 32'hFFFFFFFF, 7'b1100000));
    test_decode_vector("addi_1024", 32'h40000093,
                       exp_b(5'd0, 5'd0, 5'd0, 5'd1, 32'h00000400, 7'b1100000));
    test_decode_vector("srai", 32'h40335293, exp_b(5'd7, 5'd6, 5'd0, 5'd5, 32'h403, 7'b1100000));
    test_decode_vector("lw", 32'h00412083, exp_b(5'd0, 5'd2, 5'd0, 5'd1, 32'h4, 7'b1110000));
    test_decode_vector("sw", 32'hFE512E23,
                       exp_b(5'd0, 5'd2, 5'd5, 5'd0, 32'hFFFFFFFC, 7'b1001000));
    test_decode_vector("beq", 32'hFE208CE3,
                       exp_b(5'd1, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 7'b0000100));
    test_decode_vector("lui", 32'h123451B7,
                       exp_b(5'd0, 5'd0, 5'd0, 5'd3, 32'h12345000, 7'b1100000));
    test_decode_vector("jal", 32'h010000EF, exp_b(5'd0, 5'd0, 5'd0, 5'd1, 32'h10, 7'b1100010));
    test_decode_vector("rd0_nowrite", 32'h00000013, exp_b(5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 7'b1000000));
  endtask

  task automatic test_illegal();
    send(32'h023100B3, 32'h0000_2000);
    tests++;
    if (ill0 !== 1'b1 || rw0 !== 1'b0 || out_valid0 !== 1'b1) begin
      fails++;
      $display("FAIL mul_no_m: illegal=%b reg_write=%b valid=%b, want 1/0/1", ill0, rw0, out_valid0);
    end
    tests++;
    if (obs1 !== exp_b(5'd10, 5'd2, 5'd3, 5'd1, 32'h0, 7'b0100000)) begin
      fails++;
      $display("FAIL mul_with_m: bundle=%h, want %h", obs1,
               exp_b(5'd10, 5'd2, 5'd3, 5'd1, 32'h0, 7'b0100000));
    end
    send(32'hFFFFFFFF, 32'h0000_2004);
    tests++;
    if (ill0 !== 1'b1 || {rw0, mr0, mw0, br0, j0} !== 5'b0 || out_valid0 !== 1'b1) begin
      fails++;
      $display("FAIL bad_opcode: illegal=%b strobes=%b valid=%b, want 1/00000/1", ill0,
               {rw0, mr0, mw0, br0, j0}, out_valid0);
    end
    send(32'h00003083, 32'h0000_2008);
    tests++;
    if (ill0 !== 1'b1 || mr0 !== 1'b0 || rw0 !== 1'b0) begin
      fails++;
      $display("FAIL bad_load_f3: illegal=%b mem_read=%b reg_write=%b, want 1/0/0", ill0, mr0, rw0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    prog[0] = 32'h00100093;
    prog[1] = 32'h00200113;
    prog[2] = 32'h00300193;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = prog[i];
      in_pc    = 32'h200 + 32'(4 * i);
      tick();
      tests++;
      if (out_valid0 !== 1'b1 || pc0 !== 32'h200 + 32'(4 * i) || rd0 !== 5'(i + 1)) begin
        fails++;
        $display("FAIL b2b_%0d: valid=%b pc=%h rd=%0d, want 1 %h %0d", i, out_valid0, pc0, rd0,
                 32'h200 + 32'(4 * i), i + 1);
      end
    end
    in_valid = 1'b0;
    tick();
    tests++;
    if (out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drain: valid=%b, want 0", out_valid0);
    end
  endtask

  task automatic test_backpressure();
    send(32'h00100093, 32'h300);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00200113;
    in_pc     = 32'h304;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (out_valid0 !== 1'b1 || pc0 !== 32'h300 || rd0 !== 5'd1 || in_ready0 !== 1'b0) begin
        fails++;
        $display("FAIL stall_%0d: valid=%b pc=%h rd=%0d in_ready=%b, want 1 300 1 0", k,
                 out_valid0, pc0, rd0, in_ready0);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready0 !== 1'b1) begin
      fails++;
      $display("FAIL ready_path: in_ready=%b, want 1", in_ready0);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out_valid0 !== 1'b1 || pc0 !== 32'h304 || rd0 !== 5'd2) begin
      fails++;
      $display("FAIL release: valid=%b pc=%h rd=%0d, want 1 304 2", out_valid0, pc0, rd0);
    end
    tick();
    tests++;
    if (out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL no_dup: valid=%b, want 0", out_valid0);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h00100093, 32'h400);
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h00300193;
    in_pc     = 32'h404;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++;
    if (out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL flush: valid=%b, want 0", out_valid0);
    end
    tick();
    tests++;
    if (out_valid0 !== 1'b0) begin
      fails++;
      $display("FAIL flush_drop: valid=%b pc=%h, want valid 0", out_valid0, pc0);
    end
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    send(32'h123451B7, 32'h500);
    tests++;
    if (out_valid1 !== 1'b1 || rd1 !== 5'd3) begin
      fails++;
      $display("FAIL rst_pre: valid=%b rd=%0d, want 1 3", out_valid1, rd1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid1 !== 1'b0 || obs1 !== '0 || pc1 !== 32'h0 || in_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid: valid=%b bundle=%h pc=%h in_ready=%b, want 0 0 0 1", out_valid1,
               obs1, pc1, in_ready1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_decode();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered RV32I instruction-decode pipeline stage with an optional RV32M extension. It sits between the fetch stage and the execute stage. It decodes opcode, funct3 and funct7 into an ALU operation, register indices, a sign-extended immediate, control strobes and an illegal-instruction flag. One valid/ready pipeline register isolates fetch timing from execute timing, and a flush input discards the held instruction on redirect.

## Interface
Parameters:
- XLEN, 32, datapath/PC width; only 32 is legal.
- ENABLE_M, 0, 1 = decode MUL/DIV/REM group.
- ALU_OP_W, derived, not overridable; 4 when ENABLE_M=0, 5 when ENABLE_M=1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  drop the held instruction and any same-cycle accept.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  XLEN  registered PC.
- out_alu_op  out  ALU_OP_W  ALU_* code.
- out_rs1, out_rs2, out_rd  out  5 each  register indices; zero when unused.
- out_imm  out  XLEN  sign-extended I/S/B/U/J immediate.
- out_alu_src_imm, out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_illegal  out  1 each  control strobes.

## Operation
- in_ready = !out_valid || out_ready. This is combinational and does not depend on in_valid.
- Accept happens when in_valid && in_ready && !flush. On accept, the register loads the decoded bundle and out_valid becomes 1.
- If out_valid && out_ready and there is no accept, out_valid becomes 0. Data fields hold their old values.
- If out_valid && !out_ready, all outputs hold stable. in_ready stays 0.
- flush has priority over accept. out_valid becomes 0 next cycle, and any in_valid presented in the flush cycle is dropped.
- ALU op selection:
  - R-type (0110011), funct7=0000000: funct3 selects ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
  - R-type, funct7=0100000: funct3 000 gives SUB, 101 gives SRA. Any other funct3 is illegal.
  - R-type, funct7=0000001: MUL..REMU when ENABLE_M=1, otherwise illegal.
  - Any other funct7 is illegal.
- OP-IMM (0010011): bit30 is ignored except for shifts. ADDI is always ADD. SLLI needs funct7=0000000. SRLI/SRAI are chosen by funct7 0000000/0100000. Any other shift funct7 is illegal.
- LOAD/STORE/AUIPC/JAL/JALR use ADD. BRANCH uses SUB. LUI uses ADD with rs1=0.
- An unknown opcode, or an unsupported funct3 on LOAD/STORE/BRANCH, sets out_illegal=1 with all of reg_write, mem_read, mem_write, branch and jump at 0. The bundle still flows so execute can trap.
- rd=0 forces out_reg_write=0.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready=1.
- Reset values: out_valid=0 and every data/control output 0, which means out_alu_op=ALU_ADD (code 0). in_ready=1 one cycle after reset is released.
- rst asserted mid-transfer discards the held bundle regardless of out_ready.
- rst outranks flush, which outranks accept.
- No combinational path from in_* to out_*. The only combinational path is out_ready to in_ready.

## Structure
- isa.v (shared) holds opcode, FUNCT3_*, FUNCT7_* and ALU_* constants. Extend it with ALU_MUL..ALU_REMU (codes 10-17). Base codes stay 0-9 so a 4-bit ALU is unaffected.
- Sub-module decode_comb is purely combinational: in_instr to decoded bundle, parameterised by ENABLE_M.
- decode_stage is the pipeline register plus handshake and flush logic.

## Test plan
- Reset, then in_valid=1 with in_instr=0x40B50533 (sub x10,x10,x11): next cycle out_valid=1, alu_op=ALU_SUB, rs1=10, rs2=11, rd=10, reg_write=1.
- 0xFFF00093 (addi x1,x0,-1) gives out_imm=0xFFFFFFFF, alu_src_imm=1, ALU_ADD. 0x40000093 (addi x1,x0,1024) gives ALU_ADD, not SUB, with imm=0x400.
- 0x40335293 (srai x5,x6,3) gives ALU_SRA, imm[4:0]=3.
- 0x023100B3 (mul x1,x2,x3):
  - ENABLE_M=0: out_illegal=1, reg_write=0.
  - ENABLE_M=1: ALU_MUL, illegal=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Outputs stay stable and in_ready=0. Release out_ready; the next instruction appears the following cycle, and none are lost or duplicated.
- flush asserted together with in_valid=1 while out_valid=1: next cycle out_valid=0, the offered instruction never appears. Assert rst mid-stream: out_valid=0 and all outputs 0 next cycle.
